command_sequencer: RTL

Initiator-side block for the ALU command port. It holds a small program of 12-bit commands (opcode[11:9], addr1[8:6], addr2[5:3], addr3[2:0]) and issues them one at a time to the register/ALU controller. Each issue drives `command` with a one-cycle `syscall` strobe, then waits for the controller's completion pulse and captures `y` and the O/C/Z/N flags. It counts failed CAS (opcode 3'b111) attempts and flags a timeout if the controller never answers.

---
 rtl/command_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/command_sequencer.sv
// Issues a stored program of 12-bit ALU commands one at a time, captures each result
// and flag set, counts failed CAS commands and flags a controller timeout.
module command_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_W     = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_waddr,
    input  logic [11:0]       prog_wdata,
    input  logic              cmd_done,
    input  logic [31:0]       y,
    input  logic              O,
    input  logic              C,
    input  logic              Z,
    input  logic              N,
    output logic [11:0]       command,
    output logic              syscall,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       result,
    output logic [3:0]        flags,
    output logic [ADDR_W-1:0] pc,
    output logic [7:0]        cas_fail_count
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [11:0]       mem [PROG_DEPTH];
    logic [ADDR_W:0]   len_q;
    logic [CNT_W-1:0]  tmo_cnt;
    logic [ADDR_W-1:0] pc_inc;
    logic [11:0]       launch_cmd;
    logic              last_cmd;
    logic              launch;
    logic              advance;
    logic              complete;
    logic              timeout_hit;

    assign pc_inc   = pc + ADDR_W'(1);
    assign last_cmd = ({1'b0, pc} + (ADDR_W+1)'(1)) == len_q;
    // A write to entry 0 in the start cycle must be seen by the first issue.
    assign launch_cmd = (prog_we && prog_waddr == '0) ? prog_wdata : mem[0];

    always_ff @(posedge clk) begin
        if (state == IDLE && prog_we)
            mem[prog_waddr] <= prog_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next  = state;
        launch      = 1'b0;
        advance     = 1'b0;
        complete    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (prog_len == '0) begin
                        state_next = FINISH;
                    end else begin
                        state_next = ISSUE;
                        launch     = 1'b1;
                    end
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (cmd_done) begin
                    complete = 1'b1;
                    if (last_cmd) begin
                        state_next = FINISH;
                    end else begin
                        state_next = ISSUE;
                        advance    = 1'b1;
                    end
                end else if (tmo_cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = FINISH;
                end
            end
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            command        <= '0;
            syscall        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            result         <= '0;
            flags          <= '0;
            pc             <= '0;
            cas_fail_count <= '0;
            len_q          <= '0;
            tmo_cnt        <= '0;
        end else begin
            syscall <= (state_next == ISSUE);
            busy    <= (state_next == ISSUE) || (state_next == WAIT);
            done    <= (state_next == FINISH);

            if (launch) begin
                pc             <= '0;
                error          <= 1'b0;
                cas_fail_count <= '0;
                len_q          <= prog_len;
                command        <= launch_cmd;
            end

            if (advance) begin
                pc      <= pc_inc;
                command <= mem[pc_inc];
            end

            if (state == ISSUE)
                tmo_cnt <= '0;
            else if (state == WAIT && !cmd_done)
                tmo_cnt <= tmo_cnt + CNT_W'(1);

            if (complete) begin
                result <= y;
                flags  <= {O, C, Z, N};
                if (command[11:9] == 3'b111 && !Z && cas_fail_count != '1)
                    cas_fail_count <= cas_fail_count + 8'd1;
            end

            if (timeout_hit)
                error <= 1'b1;
        end
    end

endmodule
